// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-file geometry, the
// writeback request record and a one-hot helper for the busy scoreboard.
package wb_write_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 1 << REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // One-hot mask selecting architectural register rd.
   function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
      return {{(NREGS-1){1'b0}}, 1'b1} << rd;
   endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback arbiter's pipeline, long-latency and register-file
// signals. The arbiter uses the slave view; the producers/consumers around it
// (or a testbench) use the master view.
interface wb_write_arbiter_if;
   import wb_write_arbiter_pkg::*;

   logic              pipe_we;
   logic [REG_AW-1:0] pipe_rd;
   logic [XLEN-1:0]   pipe_data;
   logic              lu_issue;
   logic [REG_AW-1:0] lu_issue_rd;
   logic              lu_valid;
   logic [REG_AW-1:0] lu_rd;
   logic [XLEN-1:0]   lu_data;
   logic              lu_ready;
   logic [NREGS-1:0]  busy_vec;
   logic              wb_stall;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   modport slave (
      input  pipe_we, pipe_rd, pipe_data,
      input  lu_issue, lu_issue_rd,
      input  lu_valid, lu_rd, lu_data,
      output lu_ready, busy_vec, wb_stall,
      output rf_we, rf_waddr, rf_wdata
   );

   modport master (
      output pipe_we, pipe_rd, pipe_data,
      output lu_issue, lu_issue_rd,
      output lu_valid, lu_rd, lu_data,
      input  lu_ready, busy_vec, wb_stall,
      input  rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo: small circular buffer of long-latency writeback requests.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// Storage is not reset; only pointers and count are, which empties the queue.
module wb_write_arbiter_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  wb_req_t                push_data,
   input  logic                   pop,
   output wb_req_t                head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy bookkeeping; push+pop together keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: sole writer of the register-file write port. In-order
// pipeline writebacks take priority; long-latency results queue in a FIFO and
// drain into free slots. A busy scoreboard marks registers with a pending
// long-latency write, and a starvation counter raises wb_stall so the queue
// head is guaranteed a slot.
// Optional build macro WB_BYPASS_EN: a long-latency result that finds the FIFO
// empty and the pipeline slot free is written straight to the output stage.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_write_arbiter_if.slave   bus
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   // Registered state
   logic              rf_we_q;
   logic [REG_AW-1:0] rf_waddr_q;
   logic [XLEN-1:0]   rf_wdata_q;
   logic              rf_src_lu_q;
   logic [NREGS-1:0]  busy_q;
   logic [CW-1:0]     starve_q;
   logic              wb_stall_q;

   // Next-state values
   logic              rf_we_d;
   logic [REG_AW-1:0] rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_d;
   logic              rf_src_lu_d;
   logic [NREGS-1:0]  busy_d;
   logic [CW-1:0]     starve_d;
   logic              wb_stall_d;

   // Decode and FIFO control
   logic                   pipe_ok;
   logic                   lu_take;
   logic                   bypass;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   wb_req_t                fifo_head;
   wb_req_t                lu_req;

   assign lu_req = '{rd: bus.lu_rd, data: bus.lu_data};

   wb_write_arbiter_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (lu_req),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Readiness depends only on the registered occupancy, never on lu_valid.
   assign bus.lu_ready = !fifo_full;
   assign bus.busy_vec = busy_q;
   assign bus.wb_stall = wb_stall_q;
   assign bus.rf_we    = rf_we_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

   // Slot arbitration, busy scoreboard update and starvation tracking.
   always_comb begin
      pipe_ok     = bus.pipe_we && (bus.pipe_rd != '0);
      lu_take     = bus.lu_valid && bus.lu_ready && (bus.lu_rd != '0);
`ifdef WB_BYPASS_EN
      bypass      = fifo_empty && !pipe_ok && bus.lu_valid && (bus.lu_rd != '0);
`else
      bypass      = 1'b0;
`endif
      fifo_push   = lu_take && !bypass;
      fifo_pop    = !pipe_ok && !fifo_empty;

      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      rf_src_lu_d = 1'b0;
      if (pipe_ok) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.pipe_rd;
         rf_wdata_d = bus.pipe_data;
      end else if (fifo_pop) begin
         rf_we_d     = 1'b1;
         rf_waddr_d  = fifo_head.rd;
         rf_wdata_d  = fifo_head.data;
         rf_src_lu_d = 1'b1;
      end else if (bypass) begin
         rf_we_d     = 1'b1;
         rf_waddr_d  = bus.lu_rd;
         rf_wdata_d  = bus.lu_data;
         rf_src_lu_d = 1'b1;
      end

      // Clear first so a same-edge set on the same register wins.
      busy_d = busy_q;
      if (rf_we_q && rf_src_lu_q) busy_d = busy_d & ~rd_onehot(rf_waddr_q);
      if (bus.lu_issue && (bus.lu_issue_rd != '0)) busy_d = busy_d | rd_onehot(bus.lu_issue_rd);

      starve_d   = '0;
      wb_stall_d = 1'b0;
      if (pipe_ok && (fifo_count != '0)) begin
         if (starve_q == CW'(STARVE_MAX - 1)) begin
            wb_stall_d = 1'b1;
         end else begin
            starve_d = starve_q + CW'(1);
         end
      end
   end

   // Output stage, scoreboard and starvation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         rf_src_lu_q <= 1'b0;
         busy_q      <= '0;
         starve_q    <= '0;
         wb_stall_q  <= 1'b0;
      end else begin
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         rf_src_lu_q <= rf_src_lu_d;
         busy_q      <= busy_d;
         starve_q    <= starve_d;
         wb_stall_q  <= wb_stall_d;
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: scoreboard queues of expected register-file
// writes (pipeline and long-latency) checked by a monitor, plus directed
// latency, backpressure, starvation, scoreboard and reset checks.
module tb_wb_write_arbiter;
   import wb_write_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_write_arbiter_if bus ();

   wb_write_arbiter #(
      .DEPTH      (4),
      .STARVE_MAX (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   wb_req_t pipe_q[$];
   wb_req_t lu_q[$];
   logic pipe_due;

`ifdef WB_BYPASS_EN
   localparam int LU_LAT = 1;
`else
   localparam int LU_LAT = 2;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.pipe_we     = 1'b0;
      bus.pipe_rd     = '0;
      bus.pipe_data   = '0;
      bus.lu_issue    = 1'b0;
      bus.lu_issue_rd = '0;
      bus.lu_valid    = 1'b0;
      bus.lu_rd       = '0;
      bus.lu_data     = '0;
   endtask

   task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d);
      bus.pipe_we   = 1'b1;
      bus.pipe_rd   = rd;
      bus.pipe_data = d;
      if (rd != 5'd0) pipe_q.push_back('{rd: rd, data: d});
   endtask

   task automatic drive_lu(input logic [4:0] rd, input logic [31:0] d);
      bus.lu_valid = 1'b1;
      bus.lu_rd    = rd;
      bus.lu_data  = d;
      if (bus.lu_ready && rd != 5'd0) lu_q.push_back('{rd: rd, data: d});
   endtask

   task automatic drain();
      int n;
      n = 0;
      set_idle();
      while ((pipe_q.size() + lu_q.size()) != 0 && n < 60) begin
         step();
         n++;
      end
      step();
      check("drain_left", 32'(pipe_q.size() + lu_q.size()), 32'd0);
   endtask

   // Issue, deliver and retire one long-latency result; measures latency.
   task automatic lu_single(input logic [4:0] rd, input logic [31:0] d);
      int lat;
      set_idle();
      bus.lu_issue    = 1'b1;
      bus.lu_issue_rd = rd;
      step();
      set_idle();
      check("busy_set", 32'(bus.busy_vec[rd]), 32'd1);
      step();
      step();
      drive_lu(rd, d);
      step();
      set_idle();
      lat = 1;
      while (!bus.rf_we && lat < 6) begin
         step();
         lat++;
      end
      check("lu_latency", 32'(lat), 32'(LU_LAT));
      check("lu_waddr", 32'(bus.rf_waddr), 32'(rd));
      check("lu_wdata", bus.rf_wdata, d);
      check("busy_held", 32'(bus.busy_vec[rd]), 32'd1);
      step();
      check("busy_clr", 32'(bus.busy_vec[rd]), 32'd0);
      check("lu_we_off", 32'(bus.rf_we), 32'd0);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_due <= 1'b0;
      else        pipe_due <= bus.pipe_we && (bus.pipe_rd != 5'd0);
   end

   // Monitor: every write must match the head of the relevant queue.
   always @(negedge clk) begin
      wb_req_t e;
      if (rst_n) begin
         if (pipe_due) begin
            check("pipe_we", 32'(bus.rf_we), 32'd1);
            if (pipe_q.size() != 0) begin
               e = pipe_q.pop_front();
               check("pipe_waddr", 32'(bus.rf_waddr), 32'(e.rd));
               check("pipe_wdata", bus.rf_wdata, e.data);
            end
         end else if (bus.rf_we) begin
            if (lu_q.size() == 0) begin
               check("spurious_we", 32'(bus.rf_we), 32'd0);
            end else begin
               e = lu_q.pop_front();
               check("lu_q_waddr", 32'(bus.rf_waddr), 32'(e.rd));
               check("lu_q_wdata", bus.rf_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic pw;
      set_idle();
      step();
      step();
      check("rst_we", 32'(bus.rf_we), 32'd0);
      check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
      check("rst_wdata", bus.rf_wdata, 32'd0);
      check("rst_busy", bus.busy_vec, 32'd0);
      check("rst_stall", 32'(bus.wb_stall), 32'd0);
      check("rst_ready", 32'(bus.lu_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // Single pipeline write
      drive_pipe(5'd5, 32'hDEADBEEF);
      step();
      set_idle();
      check("p_we", 32'(bus.rf_we), 32'd1);
      check("p_waddr", 32'(bus.rf_waddr), 32'd5);
      check("p_wdata", bus.rf_wdata, 32'hDEADBEEF);
      step();
      check("p_we_off", 32'(bus.rf_we), 32'd0);

      // Long-latency result through the scoreboard
      lu_single(5'd7, 32'h0000_1234);

      // Continuous pipeline traffic, four queued results, starvation stall
      for (int k = 0; k < 44; k++) begin
         pw = (k < 40) && !bus.wb_stall;
         set_idle();
         if (pw) drive_pipe(5'((k % 6) + 1), $urandom);
         if (k < 4) begin
            check("t4_ready_pre", 32'(bus.lu_ready), 32'd1);
            drive_lu(5'(20 + k), $urandom);
         end
         step();
         if (k == 3) check("t4_ready_full", 32'(bus.lu_ready), 32'd0);
         if (k == 7) check("t4_stall_pre", 32'(bus.wb_stall), 32'd0);
         if (k == 8) check("t4_stall", 32'(bus.wb_stall), 32'd1);
         if (k == 9) check("t4_ready_pop", 32'(bus.lu_ready), 32'd1);
      end
      drain();

      // rd==0 results and rd==0 pipeline writes
      set_idle();
      drive_lu(5'd0, 32'hFFFFFFFF);
      step();
      set_idle();
      check("lu_rd0_we", 32'(bus.rf_we), 32'd0);
      step();
      check("lu_rd0_we2", 32'(bus.rf_we), 32'd0);
      drive_pipe(5'd0, 32'h1111_2222);
      step();
      set_idle();
      check("pipe_rd0_we", 32'(bus.rf_we), 32'd0);
      for (int k = 0; k < 6; k++) begin
         set_idle();
         if (k < 5) drive_pipe(5'(k + 1), $urandom);
         else       drive_pipe(5'd0, 32'h5555_AAAA);
         if (k < 3)       drive_lu(5'(16 + k), $urandom);
         else if (k == 3) drive_lu(5'd0, 32'hFFFFFFFF);
         else if (k == 4) drive_lu(5'd19, $urandom);
         step();
         if (k == 3) check("rd0_no_count", 32'(bus.lu_ready), 32'd1);
         if (k == 4) check("rd0_then_full", 32'(bus.lu_ready), 32'd0);
         if (k == 5) begin
            check("rd0_slot_we", 32'(bus.rf_we), 32'd1);
            check("rd0_slot_addr", 32'(bus.rf_waddr), 32'd16);
         end
      end
      drain();

      // Direct-path latency check
      lu_single(5'd9, 32'h0000_A5A5);

      // Reset in the middle of a burst with three entries queued
      for (int k = 0; k < 4; k++) begin
         set_idle();
         drive_pipe(5'(k + 1), $urandom);
         if (k < 3) drive_lu(5'(24 + k), $urandom);
         if (k == 0) begin
            bus.lu_issue    = 1'b1;
            bus.lu_issue_rd = 5'd27;
         end
         step();
      end
      check("pre_rst_busy", 32'(bus.busy_vec[27]), 32'd1);
      set_idle();
      rst_n = 1'b0;
      #1;
      pipe_q.delete();
      lu_q.delete();
      check("mid_rst_we", 32'(bus.rf_we), 32'd0);
      check("mid_rst_waddr", 32'(bus.rf_waddr), 32'd0);
      check("mid_rst_wdata", bus.rf_wdata, 32'd0);
      check("mid_rst_busy", bus.busy_vec, 32'd0);
      check("mid_rst_stall", 32'(bus.wb_stall), 32'd0);
      check("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("post_rst_we", 32'(bus.rf_we), 32'd0);
      end
      check("post_rst_ready", 32'(bus.lu_ready), 32'd1);
      check("post_rst_busy", bus.busy_vec, 32'd0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
